ara_inval_sink: RTL and testbench

- Receiving end of the Ara-to-CVA6 L1 data-cache invalidation interface.
- Accepts invalidation requests from the AXI invalidation filter over a valid/ready handshake.
- Buffers them in a small FIFO and drops redundant back-to-back requests to the same cache line.
- Drives each line-aligned invalidation into the L1 D$ tag-invalidate port with a req/gnt handshake.
- Sits between the invalidation filter output and the D$ controller in the CVA6 subsystem.

---
 rtl/ara_inval_sink.sv | 137 +++++++++++++
 tb/tb_ara_inval_sink.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ara_inval_sink.sv
// Receiving end of the Ara-to-CVA6 D$ invalidation path: buffers line addresses,
// drops back-to-back duplicates, and replays each line to the D$ tag-invalidate port.
module ara_inval_sink #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] inval_addr_i,
    input  logic                 inval_valid_i,
    output logic                 inval_ready_o,
    output logic                 dcache_req_o,
    output logic [AddrWidth-1:0] dcache_addr_o,
    input  logic                 dcache_gnt_i,
    output logic                 busy_o,
    output logic [15:0]          drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [AddrWidth-1:0] LineMask = ~AddrWidth'(L1LineWidth - 1);

    typedef enum logic {IDLE, REQ} state_e;

    logic [AddrWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 tail_valid_q, tail_valid_d;
    logic [AddrWidth-1:0] tail_line_q, tail_line_d;
    logic [AddrWidth-1:0] head_q, head_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    state_e               state_q, state_d;

    logic [AddrWidth-1:0] in_line;
    logic                 full, accept, pop, dup, drop, push;

    assign in_line = inval_addr_i & LineMask;
    assign full    = (count_q == CntW'(Depth));
    // Gated by reset so upstream never sees a handshake while we are held in reset.
    assign inval_ready_o = rst_ni & ~full;
    assign accept  = inval_valid_i & inval_ready_o;
    assign pop     = (state_q == REQ) & dcache_gnt_i;
    // The tail only counts as a duplicate source while it is still waiting for its grant.
    assign dup     = tail_valid_q & ~(pop & (count_q == CntW'(1))) & (in_line == tail_line_q);
    assign drop    = accept & (~en_i | dup);
    assign push    = accept & ~drop;

    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tail_valid_d = tail_valid_q;
        tail_line_d  = tail_line_q;
        head_d       = head_q;
        drop_cnt_d   = drop_cnt_q;

        if (push) begin
            wr_ptr_d     = wr_ptr_q + PtrW'(1);
            tail_valid_d = 1'b1;
            tail_line_d  = in_line;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
            if (count_q == CntW'(1)) begin
                tail_valid_d = 1'b0;
            end
        end

        // Head register: takes the incoming line when it lands in an otherwise empty FIFO.
        if (count_d != '0) begin
            if ((count_q == '0) || (pop && (count_q == CntW'(1)))) begin
                head_d = in_line;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        dcache_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_d != '0) state_d = REQ;
            end
            REQ: begin
                dcache_req_o = 1'b1;
                if (pop && (count_d == '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_line;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tail_valid_q <= 1'b0;
            tail_line_q  <= '0;
            head_q       <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tail_valid_q <= tail_valid_d;
            tail_line_q  <= tail_line_d;
            head_q       <= head_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign dcache_addr_o = head_q;
    assign busy_o        = (count_q != '0) | (state_q == REQ);
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_ara_inval_sink.sv
// Directed bench for ara_inval_sink: handshake, dedup, backpressure, disable,
// drop-counter saturation and asynchronous reset.
module tb_ara_inval_sink;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic [63:0] inval_addr_i = '0;
    logic        inval_valid_i = 1'b0;
    logic        inval_ready_o;
    logic        dcache_req_o;
    logic [63:0] dcache_addr_o;
    logic        dcache_gnt_i = 1'b0;
    logic        busy_o;
    logic [15:0] drop_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    ara_inval_sink #(.AddrWidth(64), .L1LineWidth(16), .Depth(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .inval_addr_i  (inval_addr_i),
        .inval_valid_i (inval_valid_i),
        .inval_ready_o (inval_ready_o),
        .dcache_req_o  (dcache_req_o),
        .dcache_addr_o (dcache_addr_o),
        .dcache_gnt_i  (dcache_gnt_i),
        .busy_o        (busy_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset
        tick();
        chk("rst_ready", 64'(inval_ready_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        chk("post_ready", 64'(inval_ready_o), 64'd1);
        chk("post_req", 64'(dcache_req_o), 64'd0);
        chk("post_addr", dcache_addr_o, 64'd0);
        chk("post_busy", 64'(busy_o), 64'd0);
        chk("post_drop", 64'(drop_cnt_o), 64'd0);

        // Single request, held without grant
        en_i = 1'b1;
        inval_valid_i = 1'b1;
        inval_addr_i = 64'h8000_1234;
        tick();
        inval_valid_i = 1'b0;
        chk("single_req", 64'(dcache_req_o), 64'd1);
        chk("single_addr", dcache_addr_o, 64'h8000_1230);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req", 64'(dcache_req_o), 64'd1);
            chk("hold_addr", dcache_addr_o, 64'h8000_1230);
        end
        dcache_gnt_i = 1'b1;
        tick();
        dcache_gnt_i = 1'b0;
        chk("single_busy", 64'(busy_o), 64'd0);
        chk("single_idle", 64'(dcache_req_o), 64'd0);
        chk("idle_addr", dcache_addr_o, 64'h8000_1230);

        // Dedup against the pending tail; a granted line is not deduplicated
        inval_valid_i = 1'b1;
        inval_addr_i = 64'h100;
        tick();
        inval_addr_i = 64'h10C;
        tick();
        inval_valid_i = 1'b0;
        chk("dedup_drop", 64'(drop_cnt_o), 64'd1);
        chk("dedup_addr", dcache_addr_o, 64'h100);
        dcache_gnt_i = 1'b1;
        inval_valid_i = 1'b1;
        inval_addr_i = 64'h104;
        tick();
        dcache_gnt_i = 1'b0;
        inval_valid_i = 1'b0;
        chk("regrant_req", 64'(dcache_req_o), 64'd1);
        chk("regrant_addr", dcache_addr_o, 64'h100);
        chk("regrant_drop", 64'(drop_cnt_o), 64'd1);
        dcache_gnt_i = 1'b1;
        tick();
        dcache_gnt_i = 1'b0;
        chk("dedup_done", 64'(busy_o), 64'd0);

        // Fill to full, then attempt push while a grant pops
        inval_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inval_addr_i = 64'(i * 16);
            chk("fill_ready", 64'(inval_ready_o), 64'd1);
            tick();
        end
        chk("full_ready", 64'(inval_ready_o), 64'd0);
        chk("full_head", dcache_addr_o, 64'h000);
        inval_addr_i = 64'h040;
        dcache_gnt_i = 1'b1;
        tick();
        inval_valid_i = 1'b0;
        chk("g1_addr", dcache_addr_o, 64'h010);
        chk("g1_ready", 64'(inval_ready_o), 64'd1);
        tick();
        chk("g2_addr", dcache_addr_o, 64'h020);
        tick();
        chk("g3_addr", dcache_addr_o, 64'h030);
        chk("g3_req", 64'(dcache_req_o), 64'd1);
        tick();
        dcache_gnt_i = 1'b0;
        chk("drain_busy", 64'(busy_o), 64'd0);
        chk("full_nodrop", 64'(drop_cnt_o), 64'd1);

        // Disabled mode drops
        en_i = 1'b0;
        inval_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inval_addr_i = 64'h200 + 64'(i * 16);
            tick();
            chk("dis_req", 64'(dcache_req_o), 64'd0);
        end
        inval_valid_i = 1'b0;
        chk("dis_drop", 64'(drop_cnt_o), 64'd6);
        chk("dis_busy", 64'(busy_o), 64'd0);

        // Buffered entries drain after en_i falls
        en_i = 1'b1;
        inval_valid_i = 1'b1;
        inval_addr_i = 64'h300;
        tick();
        inval_addr_i = 64'h310;
        tick();
        inval_valid_i = 1'b0;
        en_i = 1'b0;
        tick();
        chk("en_off_req", 64'(dcache_req_o), 64'd1);
        dcache_gnt_i = 1'b1;
        chk("drain_a", dcache_addr_o, 64'h300);
        tick();
        chk("drain_b", dcache_addr_o, 64'h310);
        tick();
        dcache_gnt_i = 1'b0;
        chk("drain_end", 64'(busy_o), 64'd0);
        chk("drain_drop", 64'(drop_cnt_o), 64'd6);

        // Saturation: 65540 disabled drops from 6
        inval_valid_i = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            inval_addr_i = 64'(i * 16);
            tick();
        end
        chk("sat_drop", 64'(drop_cnt_o), 64'hFFFF);
        tick();
        tick();
        inval_valid_i = 1'b0;
        chk("sat_hold", 64'(drop_cnt_o), 64'hFFFF);

        // Asynchronous reset mid-request
        en_i = 1'b1;
        inval_valid_i = 1'b1;
        inval_addr_i = 64'h400;
        tick();
        inval_addr_i = 64'h410;
        tick();
        inval_valid_i = 1'b0;
        chk("pre_rst_req", 64'(dcache_req_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_req", 64'(dcache_req_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_drop", 64'(drop_cnt_o), 64'd0);
        chk("arst_ready", 64'(inval_ready_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rel_busy", 64'(busy_o), 64'd0);
        chk("rel_ready", 64'(inval_ready_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
